// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
module fifo_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_SIZE = 32,
  parameter int BURST_LEN = 4,
  localparam int GID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         full,
  output logic                         w_en,
  output logic [DATA_SIZE-1:0]         w_data,
  output logic [GID_W-1:0]             grant_id,
  output logic                         busy
);
  localparam int CW = $clog2(BURST_LEN) + 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d, last_grant_q, last_grant_d, winner;
  logic last_beat;
  int j;
  // Scan from the highest offset down so the nearest requester after last_grant wins.
  always_comb begin
    winner = '0;
    j = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(last_grant_q) + k) % NUM_REQ;
      if (req_valid[GID_W'(j)]) winner = GID_W'(j);
    end
  end
  assign busy = state_q == GRANT;
  assign w_en = busy & req_valid[grant_id_q] & ~full;
  assign req_ready = {{(NUM_REQ-1){1'b0}}, w_en} << grant_id_q;
  assign w_data = req_data[grant_id_q*DATA_SIZE +: DATA_SIZE];
  assign grant_id = grant_id_q;
  assign last_beat = beat_cnt_q == CW'(BURST_LEN - 1);
  always_comb begin
    state_d = state_q;
    beat_cnt_d = beat_cnt_q;
    grant_id_d = grant_id_q;
    last_grant_d = last_grant_q;
    if (!busy) begin
      if (|req_valid) begin
        state_d = GRANT;
        grant_id_d = winner;
        last_grant_d = winner;
        beat_cnt_d = '0;
      end
    end else if (w_en) begin
      state_d = last_beat ? IDLE : GRANT;
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
    end else if (!req_valid[grant_id_q]) begin
      state_d = IDLE;
      beat_cnt_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      beat_cnt_q <= '0;
      grant_id_q <= '0;
      last_grant_q <= GID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      beat_cnt_q <= beat_cnt_d;
      grant_id_q <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: randomized scoreboard bench against a round-robin burst reference model.
module tb_fifo_write_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int BL = 4;
  logic clk = 0;
  logic rstn = 1;
  logic [N-1:0] req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic full = 0;
  logic w_en;
  logic [DW-1:0] w_data;
  logic [1:0] grant_id;
  logic busy;
  fifo_write_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .full(full), .w_en(w_en), .w_data(w_data), .grant_id(grant_id), .busy(busy)
  );
  always #5 clk = ~clk;
  int vecs = 0;
  int errs = 0;
  int rem[N];
  int seq[N];
  int drop_pct = 0;
  logic [N-1:0] acc = '0;
  logic [DW+1:0] wr_q[$];
  int m_state, m_g, m_last, m_beats;
  task automatic chk(input string name, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] word(input int i);
    return {8'(i), 24'(seq[i])};
  endfunction
  function automatic void model_reset();
    m_state = 0;
    m_g = 0;
    m_last = N - 1;
    m_beats = 0;
  endfunction
  // One cycle of the arbiter contract: idle picks nearest valid after last winner, grant moves beats.
  function automatic void model(input logic [N-1:0] v, input logic f);
    if (m_state == 0) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (v[i]) begin
          m_g = i;
          m_last = i;
          m_beats = 0;
          m_state = 1;
          break;
        end
      end
    end else if (v[m_g] && !f) begin
      wr_q.push_back({2'(m_g), word(m_g)});
      m_beats++;
      if (m_beats == BL) m_state = 0;
    end else if (!v[m_g]) begin
      m_state = 0;
    end
  endfunction
  task automatic cycle(input logic f);
    logic [N-1:0] v;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        rem[i]--;
        seq[i]++;
      end
    end
    acc = '0;
    for (int i = 0; i < N; i++) begin
      v[i] = rem[i] > 0 && int'($urandom_range(99)) >= drop_pct;
      req_data[i*DW +: DW] = word(i);
    end
    req_valid = v;
    full = f;
    model(v, f);
    #2 acc = req_valid & req_ready;
  endtask
  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += rem[i] - int'(acc[i]);
    return s;
  endfunction
  task automatic drain();
    int n = 0;
    while (pending() != 0 && n < 300) begin
      cycle(0);
      n++;
    end
    chk("drain_pending", pending(), 0);
  endtask
  task automatic apply_reset();
    #1 rstn = 0;
    req_valid = '0;
    #1;
    chk("rst_w_en", w_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_queue", wr_q.size(), 0);
    wr_q.delete();
    acc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask
  initial begin
    logic [N-1:0] one;
    logic [DW+1:0] e;
    one = 1;
    forever begin
      @(negedge clk);
      #2;
      if (rstn) begin
        chk("ready_onehot", req_ready, w_en ? one << grant_id : '0);
        if (w_en) begin
          if (wr_q.size() == 0) chk("unexpected_write", {grant_id, w_data}, -1);
          else begin
            e = wr_q.pop_front();
            chk("write_id_data", {grant_id, w_data}, e);
          end
        end
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    int base;
    int n;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
    model_reset();
    @(negedge clk);
    #2 apply_reset();
    rem[0] = 6;
    drain();
    for (int i = 0; i < N; i++) rem[i] = 4;
    drain();
    base = seq[2];
    rem[2] = 4;
    n = 0;
    while (seq[2] + int'(acc[2]) - base < 2 && n < 20) begin
      cycle(0);
      n++;
    end
    chk("stall_reach", seq[2] + int'(acc[2]) - base, 2);
    repeat (3) begin
      cycle(1);
      chk("stall_grant", {busy, grant_id}, 3'b110);
      chk("stall_ready", req_ready, 0);
    end
    drain();
    rem[1] = 1;
    rem[2] = 2;
    drain();
    chk("early_release_gid", grant_id, 2);
    base = seq[3];
    rem[3] = 8;
    n = 0;
    while (seq[3] + int'(acc[3]) - base < 2 && n < 20) begin
      cycle(0);
      n++;
    end
    chk("midburst_reach", seq[3] + int'(acc[3]) - base, 2);
    apply_reset();
    rem[0] = 3;
    cycle(0);
    cycle(0);
    chk("post_reset_grant", {busy, grant_id}, 3'b100);
    drain();
    drop_pct = 10;
    repeat (600) begin
      if ($urandom_range(9) == 0) rem[int'($urandom_range(N - 1))] += int'($urandom_range(6, 1));
      cycle($urandom_range(3) == 0);
    end
    drop_pct = 0;
    drain();
    cycle(0);
    chk("leftover_expected", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
